// File: rtl/button_cond.sv
// button_cond: per-channel push-button conditioner.
// Sync, debounce, press/release pulses, long-press and auto-repeat.
module button_cond #(
  parameter int N_BTN           = 4,
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int REPEAT_EN       = 1
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int CPM  = CLK_HZ / 1000;
  localparam int DB_R = CPM * DEBOUNCE_MS;
  localparam int RD_R = CPM * REPEAT_DELAY_MS;
  localparam int RR_R = CPM * REPEAT_RATE_MS;
  localparam int DB   = (DB_R < 1) ? 1 : DB_R;
  localparam int RD   = (RD_R < 1) ? 1 : RD_R;
  localparam int RR   = (RR_R < 1) ? 1 : RR_R;
  localparam int HMAX = ((RD > RR) ? RD : RR) - 1;
  localparam int DBW  = (DB > 1) ? $clog2(DB) : 1;
  localparam int HCW  = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

  localparam logic [DBW-1:0] DB_END = DBW'(DB - 1);
  localparam logic [HCW-1:0] RD_END = HCW'(RD - 1);
  localparam logic [HCW-1:0] RR_END = HCW'(RR - 1);
  localparam logic           REP_ON = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  // Two-flop synchronizer on every raw button bit
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [DBW-1:0] db_cnt;
    logic           lvl;
    logic           diff;
    logic           done;
    logic           rise;
    logic           fall;
    state_t         st_q;
    state_t         st_d;
    logic [HCW-1:0] hc_q;
    logic [HCW-1:0] hc_d;
    logic           prs_q;
    logic           prs_d;
    logic           rel_q;
    logic           rel_d;
    logic           lng_q;
    logic           lng_d;

    assign diff = sync2[i] ^ lvl;
    assign done = diff && (db_cnt == DB_END);
    assign rise = done && !lvl;
    assign fall = done && lvl;

    // Debounce: count mismatch cycles, flip level at terminal count
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt <= '0;
        lvl    <= 1'b0;
      end else begin
        if (!diff || done) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
        if (done) begin
          lvl <= ~lvl;
        end
      end
    end

    // Hold FSM state, hold counter and registered pulse outputs
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= IDLE;
        hc_q  <= '0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
        lng_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        hc_q  <= hc_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
        lng_q <= lng_d;
      end
    end

    // Next state; a level fall overrides everything so press never meets release
    always_comb begin
      st_d  = st_q;
      hc_d  = hc_q;
      prs_d = 1'b0;
      rel_d = 1'b0;
      lng_d = lng_q;
      if (fall) begin
        st_d  = IDLE;
        hc_d  = '0;
        rel_d = 1'b1;
        lng_d = 1'b0;
      end else begin
        unique case (st_q)
          IDLE: begin
            if (rise) begin
              st_d  = HOLD;
              hc_d  = '0;
              prs_d = 1'b1;
            end
          end
          HOLD: begin
            if (hc_q == RD_END) begin
              st_d  = REPEAT;
              hc_d  = '0;
              lng_d = 1'b1;
              prs_d = REP_ON;
            end else begin
              hc_d = hc_q + HCW'(1);
            end
          end
          REPEAT: begin
            if (hc_q == RR_END) begin
              hc_d  = '0;
              prs_d = REP_ON;
            end else begin
              hc_d = hc_q + HCW'(1);
            end
          end
          default: begin
            st_d = IDLE;
            hc_d = '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = lvl;
    assign btn_press[i]   = prs_q;
    assign btn_release[i] = rel_q;
    assign btn_long[i]    = lng_q;
  end

endmodule

// File: tb/tb_button_cond.sv
// tb_button_cond: directed scoreboard bench for button_cond.
// Two DUTs share stimulus: auto-repeat on (d0) and off (d1).
module tb_button_cond;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  ch;
    logic [7:0]  kind;
  } ev_t;

  logic       clk_100MHz = 1'b0;
  logic       reset_n;
  logic [1:0] btn_raw;
  logic [1:0] lvl0, prs0, rel0, lng0;
  logic [1:0] lvl1, prs1, rel1, lng1;
  logic [1:0] pl0 = '0;
  logic [1:0] pl1 = '0;

  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t exp0[$];
  ev_t exp1[$];
  ev_t obs0[$];
  ev_t obs1[$];

  button_cond #(
    .N_BTN(2), .CLK_HZ(1000), .DEBOUNCE_MS(4),
    .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3), .REPEAT_EN(1)
  ) dut0 (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .btn_raw(btn_raw),
    .btn_level(lvl0), .btn_press(prs0),
    .btn_release(rel0), .btn_long(lng0)
  );

  button_cond #(
    .N_BTN(2), .CLK_HZ(1000), .DEBOUNCE_MS(4),
    .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3), .REPEAT_EN(0)
  ) dut1 (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .btn_raw(btn_raw),
    .btn_level(lvl1), .btn_press(prs1),
    .btn_release(rel1), .btn_long(lng1)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic ev_t mk(input int c, input int ch, input byte k);
    ev_t e;
    e.cyc  = 32'(c);
    e.ch   = 8'(ch);
    e.kind = k;
    return e;
  endfunction

  // Monitor: stamp output events with the edge count, sampled 1ns after the edge
  always @(posedge clk_100MHz) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (prs0[i]) obs0.push_back(mk(cyc, i, "P"));
      if (rel0[i]) obs0.push_back(mk(cyc, i, "R"));
      if (lng0[i] && !pl0[i]) obs0.push_back(mk(cyc, i, "L"));
      if (!lng0[i] && pl0[i]) obs0.push_back(mk(cyc, i, "l"));
      if (prs1[i]) obs1.push_back(mk(cyc, i, "P"));
      if (rel1[i]) obs1.push_back(mk(cyc, i, "R"));
      if (lng1[i] && !pl1[i]) obs1.push_back(mk(cyc, i, "L"));
      if (!lng1[i] && pl1[i]) obs1.push_back(mk(cyc, i, "l"));
    end
    pl0 = lng0;
    pl1 = lng1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // d: 0 = repeat-enabled DUT only, 2 = both DUTs
  task automatic ex(input int d, input int c, input int ch, input byte k);
    if (d != 1) exp0.push_back(mk(c, ch, k));
    if (d != 0) exp1.push_back(mk(c, ch, k));
  endtask

  task automatic sb_cmp(input string tag, input ev_t e[$], input ev_t o[$]);
    logic hit;
    for (int i = 0; i < e.size(); i++) begin
      hit = 1'b0;
      for (int j = 0; j < o.size(); j++) begin
        if (o[j] === e[i]) begin
          hit = 1'b1;
          o.delete(j);
          break;
        end
      end
      chk($sformatf("%s event %c ch%0d @%0d", tag, e[i].kind,
                    e[i].ch, e[i].cyc), 32'(hit), 32'd1);
    end
    if (o.size() > 0)
      $display("[TB] %s first unexpected: %c ch%0d @%0d", tag,
               o[0].kind, o[0].ch, o[0].cyc);
    chk({tag, " unexpected events"}, 32'(o.size()), 32'd0);
  endtask

  task automatic sb_check(input string tag);
    sb_cmp({tag, " d0"}, exp0, obs0);
    sb_cmp({tag, " d1"}, exp1, obs1);
    exp0.delete();
    exp1.delete();
    obs0.delete();
    obs1.delete();
  endtask

  initial begin
    int k;
    int c;
    int t0;
    reset_n = 1'b0;
    btn_raw = 2'b11;
    tick(3);
    chk("rst level d0", 32'(lvl0), 32'd0);
    chk("rst press d0", 32'(prs0), 32'd0);
    chk("rst release d0", 32'(rel0), 32'd0);
    chk("rst long d0", 32'(lng0), 32'd0);
    chk("rst level d1", 32'(lvl1), 32'd0);
    chk("rst press d1", 32'(prs1), 32'd0);
    chk("rst release d1", 32'(rel1), 32'd0);
    chk("rst long d1", 32'(lng1), 32'd0);

    // Both buttons held through reset release
    reset_n = 1'b1;
    c = cyc;
    ex(2, c + 6, 0, "P");
    ex(2, c + 6, 1, "P");
    tick(6);
    chk("T1 level d0", 32'(lvl0), 32'd3);
    chk("T1 level d1", 32'(lvl1), 32'd3);
    tick(1);
    btn_raw = 2'b00;
    k = cyc;
    ex(2, k + 6, 0, "R");
    ex(2, k + 6, 1, "R");
    tick(10);
    sb_check("T1");
    chk("T1 level after release", 32'(lvl0), 32'd0);

    // Short glitch rejected
    btn_raw = 2'b01;
    tick(3);
    btn_raw = 2'b00;
    tick(10);
    chk("T2 level", 32'(lvl0), 32'd0);
    sb_check("T2");

    // Bounce then short hold
    btn_raw = 2'b01;
    tick(2);
    btn_raw = 2'b00;
    tick(2);
    btn_raw = 2'b01;
    k = cyc;
    ex(2, k + 6, 0, "P");
    tick(8);
    btn_raw = 2'b00;
    k = cyc;
    ex(2, k + 6, 0, "R");
    tick(10);
    sb_check("T3");

    // Long hold with auto-repeat
    btn_raw = 2'b01;
    k = cyc;
    t0 = k + 6;
    ex(2, t0, 0, "P");
    ex(2, t0 + 10, 0, "L");
    for (int r = 10; r <= 28; r += 3) ex(0, t0 + r, 0, "P");
    ex(2, t0 + 31, 0, "R");
    ex(2, t0 + 31, 0, "l");
    tick(26);
    chk("T4 long mid d0", 32'(lng0), 32'd1);
    chk("T4 long mid d1", 32'(lng1), 32'd1);
    tick(5);
    btn_raw = 2'b00;
    tick(10);
    sb_check("T4");
    chk("T4 long after release", 32'(lng0), 32'd0);

    // Reset pulse while repeating
    btn_raw = 2'b01;
    k = cyc;
    ex(2, k + 6, 0, "P");
    ex(2, k + 16, 0, "L");
    ex(0, k + 16, 0, "P");
    tick(18);
    reset_n = 1'b0;
    #1;
    chk("T5 async long d0", 32'(lng0), 32'd0);
    chk("T5 async level d0", 32'(lvl0), 32'd0);
    chk("T5 async long d1", 32'(lng1), 32'd0);
    chk("T5 async level d1", 32'(lvl1), 32'd0);
    ex(2, k + 19, 0, "l");
    tick(2);
    reset_n = 1'b1;
    c = cyc;
    ex(2, c + 6, 0, "P");
    ex(2, c + 16, 0, "L");
    ex(0, c + 16, 0, "P");
    ex(0, c + 19, 0, "P");
    ex(0, c + 22, 0, "P");
    tick(17);
    btn_raw = 2'b00;
    k = cyc;
    ex(2, k + 6, 0, "R");
    ex(2, k + 6, 0, "l");
    tick(10);
    sb_check("T5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
